// File: rtl/ram_arbiter_pkg.sv
// Shared widths, owner encoding and pipeline-stage record for ram_arbiter.
// Imported by the picker, the bus interface and the top level.
package ram_arbiter_pkg;

  localparam int ADDRESS_WIDTH = 13;
  localparam int DATA_WIDTH = 64;
  localparam int MEMORY_WORDS = 6000;

  typedef enum logic {
    OWNER_0 = 1'b0,
    OWNER_1 = 1'b1
  } owner_t;

  typedef struct packed {
    logic   valid;
    owner_t owner;
    logic   write;
    logic   error;
  } stage_t;

  function automatic owner_t owner_of(input logic grant1);
    return grant1 ? OWNER_1 : OWNER_0;
  endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// Two requester ports plus the single-port RAM connection of ram_arbiter.
// master = requesters and RAM side, slave = the arbiter.
interface ram_arbiter_if
  import ram_arbiter_pkg::*;
#(
  parameter int address_width = ADDRESS_WIDTH,
  parameter int data_width = DATA_WIDTH
);

  logic                     req0_valid;
  logic                     req0_ready;
  logic                     req0_write;
  logic [address_width-1:0] req0_address;
  logic [data_width-1:0]    req0_data;

  logic                     req1_valid;
  logic                     req1_ready;
  logic                     req1_write;
  logic [address_width-1:0] req1_address;
  logic [data_width-1:0]    req1_data;

  logic                     resp0_valid;
  logic [data_width-1:0]    resp0_data;
  logic                     resp0_error;

  logic                     resp1_valid;
  logic [data_width-1:0]    resp1_data;
  logic                     resp1_error;

  logic [address_width-1:0] ram_address;
  logic [data_width-1:0]    ram_in;
  logic                     ram_write;
  logic [data_width-1:0]    ram_out;

  modport master (
    output req0_valid, req0_write,
    output req0_address, req0_data,
    output req1_valid, req1_write,
    output req1_address, req1_data,
    output ram_out,
    input  req0_ready, req1_ready,
    input  resp0_valid, resp0_data,
    input  resp0_error,
    input  resp1_valid, resp1_data,
    input  resp1_error,
    input  ram_address, ram_in,
    input  ram_write
  );

  modport slave (
    input  req0_valid, req0_write,
    input  req0_address, req0_data,
    input  req1_valid, req1_write,
    input  req1_address, req1_data,
    input  ram_out,
    output req0_ready, req1_ready,
    output resp0_valid, resp0_data,
    output resp0_error,
    output resp1_valid, resp1_data,
    output resp1_error,
    output ram_address, ram_in,
    output ram_write
  );

endinterface

// File: rtl/ram_arbiter_round_robin_picker.sv
// Two-input round-robin grant with a registered last_grant.
// Port 0 wins the first tie after reset.
module round_robin_picker
  import ram_arbiter_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] valid,
  output logic [1:0] grant
);

  owner_t last_grant;

  always_comb begin
    grant = 2'b00;
    unique case (1'b1)
      reset: grant = 2'b00;
      (!reset && valid == 2'b11):
        grant = (last_grant == OWNER_1)
              ? 2'b01 : 2'b10;
      default: grant = valid;
    endcase
  end

  // Fairness only moves on an accept.
  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant <= OWNER_1;
    end else if (|grant) begin
      last_grant <= owner_of(grant[1]);
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin two-port sequencer for a single-port synchronous RAM.
// Accept at N, RAM access at N+1, response pulse at N+2.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int memory_words = MEMORY_WORDS,
  parameter int address_width = ADDRESS_WIDTH,
  parameter int data_width = DATA_WIDTH
)
(
  input logic clock,
  input logic reset,
  ram_arbiter_if.slave bus
);

  localparam logic [31:0] words = 32'(memory_words);

  logic [1:0] grant;
  logic       accept;

  logic                     sel_write;
  logic [address_width-1:0] sel_address;
  logic [data_width-1:0]    sel_data;
  logic                     sel_error;

  stage_t s1;
  stage_t s2;

  logic                  resp_live;
  logic [data_width-1:0] resp_data;

  round_robin_picker picker (
    .clock (clock),
    .reset (reset),
    .valid ({bus.req1_valid, bus.req0_valid}),
    .grant (grant)
  );

  assign accept = |grant;
  assign bus.req0_ready = grant[0];
  assign bus.req1_ready = grant[1];

  always_comb begin
    sel_write = bus.req0_write;
    sel_address = bus.req0_address;
    sel_data = bus.req0_data;
    if (grant[1]) begin
      sel_write = bus.req1_write;
      sel_address = bus.req1_address;
      sel_data = bus.req1_data;
    end
  end

  assign sel_error = 32'(sel_address) >= words;

  // Stage 1: register the accepted request and present it to the RAM.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1 <= '0;
      bus.ram_address <= '0;
      bus.ram_in <= '0;
    end else begin
      s1.valid <= accept;
      s1.owner <= owner_of(grant[1]);
      s1.write <= sel_write & accept;
      s1.error <= sel_error & accept;
      if (accept) begin
        bus.ram_address <= sel_address;
        bus.ram_in <= sel_data;
      end
    end
  end

  // Reset also masks the stage-1 write so a dropped request never lands.
  assign bus.ram_write = s1.valid & s1.write
                       & ~s1.error & ~reset;

  // Stage 2: RAM data is now on ram_out.
  always_ff @(posedge clock) begin
    if (reset) begin
      s2 <= '0;
    end else begin
      s2 <= s1;
    end
  end

  assign resp_live = s2.valid & ~reset;
  assign resp_data = (s2.write | s2.error)
                   ? '0 : bus.ram_out;

  assign bus.resp0_valid = resp_live
                         & (s2.owner == OWNER_0);
  assign bus.resp1_valid = resp_live
                         & (s2.owner == OWNER_1);

  assign bus.resp0_data = bus.resp0_valid
                        ? resp_data : '0;
  assign bus.resp1_data = bus.resp1_valid
                        ? resp_data : '0;

  assign bus.resp0_error = bus.resp0_valid & s2.error;
  assign bus.resp1_error = bus.resp1_valid & s2.error;

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: directed scenarios plus random soak.
// A behavioural memory model predicts every response and RAM write.
module tb_ram_arbiter;

  localparam int WORDS = 6000;

  logic clock = 1'b0;
  logic reset = 1'b1;

  ram_arbiter_if bus ();

  ram_arbiter dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  logic [63:0] ram_mem [8192];
  always @(posedge clock) begin
    if (bus.ram_write) ram_mem[bus.ram_address] <= bus.ram_in;
    bus.ram_out <= ram_mem[bus.ram_address];
  end

  typedef struct {
    int          due;
    logic [63:0] data;
    logic        err;
  } exp_t;

  exp_t q [2][$];
  logic [63:0] model [WORDS];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int naccept = 0;
  int ref_last = 1;

  logic        pend_v = 1'b0;
  int          pend_p;
  logic        pend_w;
  logic [12:0] pend_a;
  logic [63:0] pend_d;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic void chk(input string name,
                              input logic [63:0] act,
                              input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endfunction

  function automatic void fail(input string name, input int act);
    checks++;
    errors++;
    $display("FAIL %s actual=%0d required=none", name, act);
  endfunction

  logic        rv [2];
  logic [63:0] rd [2];
  logic        re [2];
  logic        g0, g1, exp_wr;
  exp_t        e;

  always @(negedge clock) begin
    rv[0] = bus.resp0_valid; rd[0] = bus.resp0_data; re[0] = bus.resp0_error;
    rv[1] = bus.resp1_valid; rd[1] = bus.resp1_data; re[1] = bus.resp1_error;
    if (reset) begin
      chk("reset_quiet",
          {bus.req0_ready, bus.req1_ready, rv[0], rv[1], bus.ram_write}, 0);
      q[0].delete();
      q[1].delete();
      pend_v = 1'b0;
      ref_last = 1;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (rv[p]) begin
          if (q[p].size() == 0) begin
            fail("resp_spurious", p);
          end else begin
            e = q[p].pop_front();
            chk("resp_latency", 64'(cyc), 64'(e.due));
            chk("resp_data", rd[p], e.data);
            chk("resp_error", 64'(re[p]), 64'(e.err));
          end
        end else begin
          chk("resp_idle", {rd[p], re[p]} != 0 ? 64'd1 : 64'd0, 0);
          if (q[p].size() != 0 && q[p][0].due <= cyc) begin
            fail("resp_missing", p);
            void'(q[p].pop_front());
          end
        end
      end
      exp_wr = pend_v && pend_w && (int'(pend_a) < WORDS);
      chk("ram_write", 64'(bus.ram_write), 64'(exp_wr));
      if (pend_v) begin
        chk("ram_address", 64'(bus.ram_address), 64'(pend_a));
        if (pend_w) chk("ram_in", bus.ram_in, pend_d);
        e.due = cyc + 1;
        e.err = int'(pend_a) >= WORDS;
        e.data = (pend_w || e.err) ? 64'd0 : model[pend_a];
        if (exp_wr) model[pend_a] = pend_d;
        q[pend_p].push_back(e);
      end
      g0 = bus.req0_valid && (!bus.req1_valid || ref_last == 1);
      g1 = bus.req1_valid && !g0;
      chk("grant", {62'd0, bus.req1_ready, bus.req0_ready}, {62'd0, g1, g0});
      pend_v = g0 || g1;
      if (g0) begin
        pend_p = 0; pend_w = bus.req0_write;
        pend_a = bus.req0_address; pend_d = bus.req0_data;
      end else begin
        pend_p = 1; pend_w = bus.req1_write;
        pend_a = bus.req1_address; pend_d = bus.req1_data;
      end
      if (pend_v) begin
        ref_last = g1 ? 1 : 0;
        naccept++;
      end
    end
  end

  task automatic next();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input int p, input logic v, input logic w,
                       input logic [12:0] a, input logic [63:0] d);
    if (p == 0) begin
      bus.req0_valid = v; bus.req0_write = w;
      bus.req0_address = a; bus.req0_data = d;
    end else begin
      bus.req1_valid = v; bus.req1_write = w;
      bus.req1_address = a; bus.req1_data = d;
    end
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    next();
    @(negedge clock);
    chk("reset_ram_address", 64'(bus.ram_address), 0);
    chk("reset_ram_in", bus.ram_in, 0);
    next();
    reset = 1'b0;
  endtask

  function automatic logic [12:0] raddr();
    int s = $urandom_range(0, 9);
    if (s < 6) return 13'($urandom_range(0, 31));
    if (s < 8) return 13'($urandom_range(5990, 6009));
    return 13'($urandom_range(0, 8191));
  endfunction

  initial begin
    int start, guard;
    logic [63:0] aa;
    for (int i = 0; i < 8192; i++) ram_mem[i] = 64'd0;
    for (int i = 0; i < WORDS; i++) model[i] = 64'd0;
    idle();
    bus.ram_out = 64'd0;

    // Single write then read at address 5.
    do_reset();
    drive(0, 1, 1, 13'd5, 64'hDEADBEEF_CAFEF00D);
    @(negedge clock);
    chk("t1_accept_write", 64'(bus.req0_ready), 1);
    next();
    drive(0, 1, 0, 13'd5, 0);
    @(negedge clock);
    chk("t1_accept_read", 64'(bus.req0_ready), 1);
    next();
    idle();
    @(negedge clock);
    chk("t1_write_resp", 64'(bus.resp0_valid), 1);
    next();
    @(negedge clock);
    chk("t1_read_resp", 64'(bus.resp0_valid), 1);
    chk("t1_read_data", bus.resp0_data, 64'hDEADBEEF_CAFEF00D);
    next();

    // Sustained contention after reset alternates 0,1,0,1,...
    do_reset();
    drive(0, 1, 0, 13'd10, 0);
    drive(1, 1, 0, 13'd11, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      chk("t2_ready0", 64'(bus.req0_ready), 64'(i % 2 == 0));
      chk("t2_ready1", 64'(bus.req1_ready), 64'(i % 2 == 1));
      next();
    end
    idle();
    next(); next(); next();

    // Out-of-range write and read, then the last valid word.
    drive(1, 1, 1, 13'd6000, 64'h1234);
    next();
    drive(1, 1, 0, 13'd6000, 0);
    @(negedge clock);
    chk("t3_no_ram_write", 64'(bus.ram_write), 0);
    next();
    drive(1, 1, 0, 13'd5999, 0);
    @(negedge clock);
    chk("t3_wr_err", {bus.resp1_valid, bus.resp1_error}, 2'b11);
    chk("t3_wr_data", bus.resp1_data, 0);
    next();
    idle();
    @(negedge clock);
    chk("t3_rd_err", {bus.resp1_valid, bus.resp1_error}, 2'b11);
    chk("t3_rd_data", bus.resp1_data, 0);
    next();
    @(negedge clock);
    chk("t3_rd_ok", {bus.resp1_valid, bus.resp1_error}, 2'b10);
    next();

    // Back-to-back read-after-write across ports.
    aa = {16{4'hA}};
    drive(1, 1, 1, 13'd100, aa);
    next();
    drive(1, 0, 0, 0, 0);
    drive(0, 1, 0, 13'd100, 0);
    next();
    idle();
    next();
    @(negedge clock);
    chk("t4_raw_valid", 64'(bus.resp0_valid), 1);
    chk("t4_raw_data", bus.resp0_data, aa);
    next();

    // Reset with a read and a write in flight.
    drive(0, 1, 0, 13'd8, 0);
    next();
    drive(0, 0, 0, 0, 0);
    drive(1, 1, 1, 13'd7, 64'h5555);
    next();
    idle();
    reset = 1'b1;
    @(negedge clock);
    chk("t5_no_resp", {bus.resp0_valid, bus.resp1_valid}, 0);
    chk("t5_no_write", 64'(bus.ram_write), 0);
    next();
    @(negedge clock);
    chk("t5_no_resp2", {bus.resp0_valid, bus.resp1_valid}, 0);
    next();
    reset = 1'b0;
    drive(0, 1, 0, 13'd7, 0);
    drive(1, 1, 0, 13'd8, 0);
    @(negedge clock);
    chk("t5_tie_port0", {bus.req1_ready, bus.req0_ready}, 2'b01);
    next();
    drive(0, 0, 0, 0, 0);
    next();
    idle();
    @(negedge clock);
    chk("t5_dropped_write", {bus.resp0_valid, bus.resp0_data}, {1'b1, 64'd0});
    next();

    // Random soak on both ports.
    start = naccept;
    guard = 0;
    while (naccept - start < 2000 && guard < 6000) begin
      drive(0, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 4,
            raddr(), {$urandom, $urandom});
      drive(1, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 4,
            raddr(), {$urandom, $urandom});
      next();
      guard++;
    end
    if (guard >= 6000) fail("soak_budget", naccept - start);
    idle();
    for (int i = 0; i < 4; i++) next();
    chk("drain0", 64'(q[0].size()), 0);
    chk("drain1", 64'(q[1].size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
